// File: rtl/vm1_bus_arbiter_if.sv
// Bus-side and control-unit-side signal bundle of the vm1 bus arbiter.
// The arbiter takes the master view; a bus model or bench takes the slave view.
interface vm1_bus_arbiter_if;
  logic dati;
  logic dato;
  logic b;
  logic done;
  logic error;
  logic SYNC;
  logic DIN;
  logic DOUT;
  logic WTBT;
  logic BSY;
  logic RPLY;
  logic DMR;
  logic DMGO;
  logic SACK;
  logic dma_active;

  modport master (
    input  dati, dato, b, RPLY, DMR, SACK,
    output done, error, SYNC, DIN, DOUT, WTBT, BSY, DMGO, dma_active
  );

  modport slave (
    output dati, dato, b, RPLY, DMR, SACK,
    input  done, error, SYNC, DIN, DOUT, WTBT, BSY, DMGO, dma_active
  );
endinterface

// File: rtl/vm1_bus_arbiter.sv
// Registered Q-bus cycle sequencer with bus timeout and DMR/DMGO/SACK DMA arbitration.
// All outputs come straight from flops; inputs are only sampled on ce edges.
module vm1_bus_arbiter #(
  parameter int BUS_TIMEOUT = 63,
  parameter int TW          = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               ce,
  vm1_bus_arbiter_if.master  bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CYC   = 3'd1,
    ST_REL   = 3'd2,
    ST_TERR  = 3'd3,
    ST_GRANT = 3'd4,
    ST_DMA   = 3'd5
  } state_t;

  localparam logic [TW-1:0] CNT_LOAD = TW'(BUS_TIMEOUT);
  localparam logic [TW-1:0] CNT_ZERO = {TW{1'b0}};
  localparam logic [TW-1:0] CNT_ONE  = {{(TW-1){1'b0}}, 1'b1};

  state_t        state_r, state_s;
  logic [TW-1:0] cnt_r, cnt_s;
  logic          sync_r, sync_s;
  logic          din_r, din_s;
  logic          dout_r, dout_s;
  logic          wtbt_r, wtbt_s;
  logic          bsy_r, bsy_s;
  logic          dmgo_r, dmgo_s;
  logic          done_r, done_s;
  logic          error_r, error_s;
  logic          dma_active_r, dma_active_s;

  // State, counter and output registers; frozen while ce is low
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_LOAD;
      sync_r       <= 1'b0;
      din_r        <= 1'b0;
      dout_r       <= 1'b0;
      wtbt_r       <= 1'b0;
      bsy_r        <= 1'b0;
      dmgo_r       <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
      dma_active_r <= 1'b0;
    end else if (ce) begin
      state_r      <= state_s;
      cnt_r        <= cnt_s;
      sync_r       <= sync_s;
      din_r        <= din_s;
      dout_r       <= dout_s;
      wtbt_r       <= wtbt_s;
      bsy_r        <= bsy_s;
      dmgo_r       <= dmgo_s;
      done_r       <= done_s;
      error_r      <= error_s;
      dma_active_r <= dma_active_s;
    end else begin
      state_r      <= state_r;
      cnt_r        <= cnt_r;
      sync_r       <= sync_r;
      din_r        <= din_r;
      dout_r       <= dout_r;
      wtbt_r       <= wtbt_r;
      bsy_r        <= bsy_r;
      dmgo_r       <= dmgo_r;
      done_r       <= done_r;
      error_r      <= error_r;
      dma_active_r <= dma_active_r;
    end
  end

  // Next-state and next-output decode
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    sync_s       = sync_r;
    din_s        = din_r;
    dout_s       = dout_r;
    wtbt_s       = wtbt_r;
    bsy_s        = bsy_r;
    dmgo_s       = dmgo_r;
    dma_active_s = dma_active_r;
    done_s       = 1'b0;
    error_s      = 1'b0;

    case (state_r)
      ST_IDLE: begin
        // DMA request outranks a CPU request arriving in the same cycle
        if (bus.DMR) begin
          state_s = ST_GRANT;
          dmgo_s  = 1'b1;
          cnt_s   = CNT_LOAD;
        end else if ((bus.dati || bus.dato) && !bus.RPLY) begin
          state_s = ST_CYC;
          cnt_s   = CNT_LOAD;
          sync_s  = 1'b1;
          bsy_s   = 1'b1;
          din_s   = bus.dati;
          dout_s  = bus.dato & ~bus.dati;
          wtbt_s  = bus.b;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_CYC: begin
        if (bus.RPLY) begin
          state_s = ST_REL;
          sync_s  = 1'b0;
          din_s   = 1'b0;
          dout_s  = 1'b0;
          bsy_s   = 1'b0;
          wtbt_s  = 1'b0;
          done_s  = 1'b1;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_TERR;
          sync_s  = 1'b0;
          din_s   = 1'b0;
          dout_s  = 1'b0;
          bsy_s   = 1'b0;
          wtbt_s  = 1'b0;
          error_s = 1'b1;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_REL: begin
        if (!bus.RPLY) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_REL;
        end
      end

      ST_TERR: begin
        state_s = ST_IDLE;
      end

      ST_GRANT: begin
        if (bus.SACK) begin
          state_s      = ST_DMA;
          dmgo_s       = 1'b0;
          dma_active_s = 1'b1;
        end else if (!bus.DMR) begin
          state_s = ST_IDLE;
          dmgo_s  = 1'b0;
        end else if (cnt_r == CNT_ZERO) begin
          state_s = ST_IDLE;
          dmgo_s  = 1'b0;
        end else begin
          cnt_s = cnt_r - CNT_ONE;
        end
      end

      ST_DMA: begin
        sync_s = 1'b0;
        din_s  = 1'b0;
        dout_s = 1'b0;
        bsy_s  = 1'b0;
        wtbt_s = 1'b0;
        if (!bus.SACK) begin
          state_s      = ST_IDLE;
          dma_active_s = 1'b0;
        end else begin
          state_s = ST_DMA;
        end
      end

      default: begin
        state_s      = ST_IDLE;
        cnt_s        = CNT_LOAD;
        sync_s       = 1'b0;
        din_s        = 1'b0;
        dout_s       = 1'b0;
        wtbt_s       = 1'b0;
        bsy_s        = 1'b0;
        dmgo_s       = 1'b0;
        dma_active_s = 1'b0;
      end
    endcase
  end

  assign bus.SYNC       = sync_r;
  assign bus.DIN        = din_r;
  assign bus.DOUT       = dout_r;
  assign bus.WTBT       = wtbt_r;
  assign bus.BSY        = bsy_r;
  assign bus.DMGO       = dmgo_r;
  assign bus.done       = done_r;
  assign bus.error      = error_r;
  assign bus.dma_active = dma_active_r;

endmodule
